// File: rtl/cvxif_pkg.sv
// CV-X-IF interface parameters shared by the coprocessor blocks.
package cvxif_pkg;
  localparam int X_ID_WIDTH = 3;
endpackage

// File: rtl/mac_sched_pkg.sv
// Types and sizing for the MAC result scheduler and its result store.
package mac_sched_pkg;
  localparam int ID_W    = cvxif_pkg::X_ID_WIDTH;
  localparam int NUM_IDS = 1 << ID_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUED    = 3'd1,
    S_DONE_WAIT = 3'd2,
    S_CMT_WAIT  = 3'd3,
    S_READY     = 3'd4,
    S_DRAIN     = 3'd5,
    S_SENT      = 3'd6
  } slot_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [4:0]      rd;
  } result_t;
endpackage

// File: rtl/mac_result_store.sv
// Per-ID result storage: one synchronous write port, one combinational read port.
module mac_result_store
  import mac_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [ID_W-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [4:0]      wrd_i,
  input  logic [ID_W-1:0] raddr_i,
  output logic [31:0]     rdata_o,
  output logic [4:0]      rrd_o
);
  logic [36:0] mem_q [NUM_IDS];
  logic [36:0] mem_d [NUM_IDS];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = {wdata_i, wrd_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i][36:5];
  assign rrd_o   = mem_q[raddr_i][4:0];
endmodule

// File: rtl/mac_result_scheduler.sv
// CV-X-IF MAC writeback: per-ID issue/commit/done tracking and round-robin result scheduling.
// Result channel: result_valid_o stays high with a stable payload until result_ready_i is seen.
module mac_result_scheduler
  import mac_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_ready_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  input  logic            done_valid_i,
  input  logic [ID_W-1:0] done_id_i,
  input  logic [31:0]     done_data_i,
  input  logic [4:0]      done_rd_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [31:0]     result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            busy_o,
  output logic            err_o
);
  slot_state_e     state_q [NUM_IDS];
  slot_state_e     state_d [NUM_IDS];
  logic            out_valid_q, out_valid_d;
  result_t         out_q, out_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic            err_q, err_d;

  logic               hs, load_en, pick_found;
  logic [ID_W-1:0]    pick_id, cand;
  logic [31:0]        st_data;
  logic [4:0]         st_rd;
  logic [NUM_IDS-1:0] iss_v, cmt_v, dn_v, sel_v, snt_v;

  mac_result_store u_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (done_valid_i),
    .waddr_i (done_id_i),
    .wdata_i (done_data_i),
    .wrd_i   (done_rd_i),
    .raddr_i (pick_id),
    .rdata_o (st_data),
    .rrd_o   (st_rd)
  );

  // Round-robin search over READY slots, starting at the pointer.
  always_comb begin
    hs         = out_valid_q && result_ready_i;
    load_en    = !out_valid_q || hs;
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_IDS; k++) begin
      cand = rr_q + ID_W'(k);
      if (!pick_found && state_q[cand] == S_READY) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    iss_v = NUM_IDS'(issue_valid_i) << issue_id_i;
    cmt_v = NUM_IDS'(commit_valid_i) << commit_id_i;
    dn_v  = NUM_IDS'(done_valid_i) << done_id_i;
    sel_v = NUM_IDS'(load_en && pick_found) << pick_id;
    snt_v = NUM_IDS'(hs) << out_q.id;
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_IDS; i++) begin
      state_d[i] = state_q[i];
      if (iss_v[i] && state_q[i] != S_IDLE) err_d = 1'b1;
      if (cmt_v[i] && !(state_q[i] inside {S_ISSUED, S_DONE_WAIT})) err_d = 1'b1;
      if (dn_v[i] && !(state_q[i] inside {S_ISSUED, S_CMT_WAIT, S_DRAIN})) err_d = 1'b1;
      case (state_q[i])
        S_IDLE:      if (iss_v[i]) state_d[i] = S_ISSUED;
        S_ISSUED: begin
          if (dn_v[i] && cmt_v[i]) state_d[i] = commit_kill_i ? S_IDLE : S_READY;
          else if (dn_v[i])        state_d[i] = S_DONE_WAIT;
          else if (cmt_v[i])       state_d[i] = commit_kill_i ? S_DRAIN : S_CMT_WAIT;
        end
        S_DONE_WAIT: if (cmt_v[i]) state_d[i] = commit_kill_i ? S_IDLE : S_READY;
        S_CMT_WAIT:  if (dn_v[i])  state_d[i] = S_READY;
        S_DRAIN:     if (dn_v[i])  state_d[i] = S_IDLE;
        S_READY:     if (sel_v[i]) state_d[i] = S_SENT;
        S_SENT:      if (snt_v[i]) state_d[i] = S_IDLE;
        default:                   state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    rr_d        = rr_q;
    if (load_en) begin
      out_valid_d = pick_found;
      if (pick_found) begin
        out_d.id   = pick_id;
        out_d.data = st_data;
        out_d.rd   = st_rd;
        rr_d       = pick_id + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) state_q[i] <= S_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NUM_IDS; i++) if (state_q[i] != S_IDLE) busy_o = 1'b1;
  end

  assign issue_ready_o  = (state_q[issue_id_i] == S_IDLE);
  assign result_valid_o = out_valid_q;
  assign result_id_o    = out_q.id;
  assign result_data_o  = out_q.data;
  assign result_rd_o    = out_q.rd;
  assign result_we_o    = out_valid_q && (out_q.rd != 5'd0);
  assign err_o          = err_q;
endmodule
